// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among N_REQ valid/ready
// requesters, limiting each grant to MAX_BURST beats.
//
// state   | meaning
// S_IDLE  | no owner; scan req_valid from rr_ptr for the next owner
// S_GRANT | owner's beats are forwarded to the FIFO until release
module fifo_wr_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          wclk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]              req_ready,
   input  logic                          full,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [$clog2(N_REQ)-1:0]      grant_id,
   output logic                          busy,
   output logic [15:0]                   xfer_count
);

   localparam int IW = $clog2(N_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t          state, state_d;
   logic [IW-1:0]   owner, owner_d;
   logic [IW-1:0]   rr_ptr, rr_ptr_d;
   logic [BW-1:0]   beat_cnt, beat_d;
   logic [15:0]     xfer_d;
   logic [IW-1:0]   owner_inc;
   logic [IW-1:0]   pick;
   logic [IW:0]     cand;
   logic            found;

   assign winc      = (state == S_GRANT) & req_valid[owner] & ~full & ~rst;
   assign req_ready = winc ? (N_REQ'(1) << owner) : '0;
   assign wdata     = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
   assign grant_id  = owner;
   assign busy      = (state == S_GRANT);
   assign owner_inc = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);

   always_ff @(posedge wclk) begin
      if (rst) begin
         state      <= S_IDLE;
         owner      <= '0;
         rr_ptr     <= '0;
         beat_cnt   <= '0;
         xfer_count <= '0;
      end else begin
         state      <= state_d;
         owner      <= owner_d;
         rr_ptr     <= rr_ptr_d;
         beat_cnt   <= beat_d;
         xfer_count <= xfer_d;
      end
   end

   always_comb begin
      state_d  = state;
      owner_d  = owner;
      rr_ptr_d = rr_ptr;
      beat_d   = beat_cnt;
      xfer_d   = xfer_count;
      found    = 1'b0;
      pick     = rr_ptr;
      cand     = '0;

      // first valid requester at or after rr_ptr, wrapping modulo N_REQ
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
         if (!found && req_valid[cand[IW-1:0]]) begin
            found = 1'b1;
            pick  = cand[IW-1:0];
         end
      end

      case (state)
         S_IDLE: begin
            if (found) begin
               state_d = S_GRANT;
               owner_d = pick;
               beat_d  = '0;
            end
         end
         S_GRANT: begin
            if (!req_valid[owner]) begin
               state_d  = S_IDLE;
               rr_ptr_d = owner_inc;
               beat_d   = '0;
            end else if (winc) begin
               xfer_d = xfer_count + 16'd1;
               if (beat_cnt == BW'(MAX_BURST - 1)) begin
                  state_d  = S_IDLE;
                  rr_ptr_d = owner_inc;
                  beat_d   = '0;
               end else begin
                  beat_d = beat_cnt + BW'(1);
               end
            end
            // full stall: hold grant and burst budget
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle comparison against an
// integer-level arbitration model, directed scenarios and a random soak.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;

   logic             wclk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     req_ready;
   logic             full;
   logic             winc;
   logic [W-1:0]     wdata;
   logic [1:0]       grant_id;
   logic             busy;
   logic [15:0]      xfer_count;

   fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
      .wclk(wclk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .full(full), .winc(winc), .wdata(wdata),
      .grant_id(grant_id), .busy(busy), .xfer_count(xfer_count)
   );

   always #5 wclk = ~wclk;

   int checks = 0;
   int errors = 0;

   // model: who owns the port (if anyone), whose turn is next, beats used
   bit m_granted;
   int m_owner, m_ptr, m_beats, m_total;
   int dcnt[N];

   int s_winc, s_ready, s_wdata, s_grant, s_busy, s_xfer;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
      end
   endtask

   task automatic build_data();
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'((i * 16 + dcnt[i]) & 255);
   endtask

   task automatic model_reset();
      m_granted = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_total = 0;
   endtask

   task automatic cycle();
      int e_winc, e_ready, ow;
      bit acc;
      @(negedge wclk);
      e_winc  = (m_granted && req_valid[m_owner] && !full && !rst) ? 1 : 0;
      e_ready = e_winc ? (1 << m_owner) : 0;
      s_winc = int'(winc); s_ready = int'(req_ready); s_wdata = int'(wdata);
      s_grant = int'(grant_id); s_busy = int'(busy); s_xfer = int'(xfer_count);
      chk("winc", s_winc, e_winc);
      chk("req_ready", s_ready, e_ready);
      chk("busy", s_busy, m_granted ? 1 : 0);
      chk("grant_id", s_grant, m_owner);
      chk("xfer_count", s_xfer, m_total);
      if (e_winc == 1) chk("wdata", s_wdata, int'(req_data[m_owner*W +: W]));
      @(posedge wclk);
      acc = (e_winc == 1);
      ow  = m_owner;
      if (rst) begin
         model_reset();
      end else if (!m_granted) begin
         for (int k = 0; k < N; k++) begin
            if (!m_granted && req_valid[(m_ptr + k) % N]) begin
               m_granted = 1; m_owner = (m_ptr + k) % N; m_beats = 0;
            end
         end
      end else if (!req_valid[m_owner]) begin
         m_granted = 0; m_ptr = (m_owner + 1) % N; m_beats = 0;
      end else if (!full) begin
         m_beats++;
         m_total = (m_total + 1) % 65536;
         if (m_beats == MB) begin
            m_granted = 0; m_ptr = (m_owner + 1) % N; m_beats = 0;
         end
      end
      if (acc) dcnt[ow] = (dcnt[ow] + 1) % 16;
      #1;
      build_data();
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; full = 1'b0;
      for (int i = 0; i < N; i++) dcnt[i] = 0;
      build_data();
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      int got, pat;
      int exp_own, exp_dat;
      rst = 1'b1; req_valid = '0; full = 1'b0;
      for (int i = 0; i < N; i++) dcnt[i] = 0;
      build_data();
      @(posedge wclk); #1;
      model_reset();

      // reset values
      do_reset();
      rst = 1'b1;
      cycle();
      chk("rst_busy", s_busy, 0);
      chk("rst_winc", s_winc, 0);
      chk("rst_xfer", s_xfer, 0);
      chk("rst_grant", s_grant, 0);
      chk("rst_ready", s_ready, 0);

      // 1: single requester, burst limit 4 then one idle cycle
      do_reset();
      req_valid = 4'b0001;
      pat = 0;
      for (int c = 1; c <= 10; c++) begin
         cycle();
         pat = (pat << 1) | s_winc;
         chk("p1_grant", s_grant, 0);
      end
      chk("p1_winc_pattern", pat, 10'b0111101111);
      cycle();
      chk("p1_xfer", s_xfer, 8);

      // 2: round robin over 1111 with owner-tagged data
      do_reset();
      req_valid = 4'b1111;
      got = 0;
      for (int c = 0; c < 60 && got < 20; c++) begin
         cycle();
         if (s_winc == 1) begin
            exp_own = (got / 4) % 4;
            exp_dat = exp_own * 16 + (got % 4) + ((got >= 16) ? 4 : 0);
            chk("p2_order", s_grant, exp_own);
            chk("p2_wdata", s_wdata, exp_dat);
            got++;
         end
      end
      chk("p2_beats", got, 20);

      // 3: full stall after beat 1 of requester 2
      do_reset();
      req_valid = 4'b0100;
      cycle();
      cycle();
      chk("p3_beat1", s_winc, 1);
      full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cycle();
         chk("p3_stall_winc", s_winc, 0);
         chk("p3_stall_ready", s_ready, 0);
         chk("p3_stall_busy", s_busy, 1);
         chk("p3_stall_grant", s_grant, 2);
      end
      full = 1'b0;
      got = 0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         got += s_winc;
      end
      chk("p3_rest_beats", got, 3);
      req_valid = 4'b0000;
      cycle();
      chk("p3_release", s_busy, 0);
      chk("p3_xfer", s_xfer, 4);

      // 4: owner 1 drops valid after 2 beats, requester 3 waiting
      do_reset();
      req_valid = 4'b1010;
      cycle();
      cycle();
      chk("p4_grant1", s_grant, 1);
      cycle();
      req_valid = 4'b1000;
      cycle();
      chk("p4_drop_winc", s_winc, 0);
      chk("p4_xfer", s_xfer, 2);
      cycle();
      chk("p4_idle", s_busy, 0);
      cycle();
      chk("p4_next_busy", s_busy, 1);
      chk("p4_next_grant", s_grant, 3);

      // 5: reset during beat 3
      do_reset();
      req_valid = 4'b0001;
      cycle();
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      chk("p5_rst_winc", s_winc, 0);
      rst = 1'b0;
      req_valid = 4'b1010;
      cycle();
      chk("p5_busy", s_busy, 0);
      chk("p5_xfer", s_xfer, 0);
      cycle();
      chk("p5_grant", s_grant, 1);

      // 6: owner 3 wraps to requester 0
      do_reset();
      req_valid = 4'b1000;
      cycle();
      req_valid = 4'b1001;
      for (int c = 2; c <= 5; c++) begin
         cycle();
         chk("p6_own3", s_grant, 3);
      end
      cycle();
      chk("p6_idle1", s_busy, 0);
      cycle();
      chk("p6_wrap", s_grant, 0);
      for (int c = 8; c <= 11; c++) cycle();
      chk("p6_idle2", s_busy, 0);
      cycle();
      chk("p6_back3", s_grant, 3);

      // random soak
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(7) == 0) req_valid[i] = ~req_valid[i];
         full = ($urandom_range(3) == 0);
         rst  = ($urandom_range(99) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Round-robin arbiter that shares the write port of the async FIFO among N_REQ requesters in the wclk domain.
- Each requester presents data with a valid/ready handshake.
- The arbiter grants one owner at a time and forwards that owner's beats as winc/wdata into the FIFO write side. It honours the write-side full flag and limits each grant to MAX_BURST beats, so no requester can starve the others.

## Interface

Parameters:
- N_REQ, default 4: number of requesters; must be ≥2.
- DATA_WIDTH, default 8: width of one FIFO word.
- MAX_BURST, default 4: maximum beats per grant; must be ≥1.

Ports:
- wclk  input  1: write-domain clock; all logic is on its rising edge.
- rst  input  1: reset, synchronous and active-high.
- req_valid  input  N_REQ: requester i has a word available.
- req_data  input  N_REQ*DATA_WIDTH: requester i's word, in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  N_REQ: one-hot or zero; a word is accepted from requester i at an edge where req_valid[i] and req_ready[i] are both high.
- full  input  1: FIFO write-side full flag.
- winc  output  1: write strobe to the FIFO.
- wdata  output  DATA_WIDTH: write data to the FIFO.
- grant_id  output  clog2(N_REQ): current owner index.
- busy  output  1: high while in GRANT.
- xfer_count  output  16: total accepted beats, wrapping modulo 2^16.

## Operation

State machine has two states: IDLE and GRANT.

Registered state:
- owner
- rr_ptr, the next requester with priority
- beat_cnt, width clog2(MAX_BURST+1)
- xfer_count

Combinational outputs:
- winc = (state==GRANT) & req_valid[owner] & ~full & ~rst.
- req_ready[i] = winc & (i==owner).
- wdata = req_data slice of owner. It is valid only while winc is high; otherwise it is don't-care, but it is still driven from owner with no X.
- grant_id = owner.
- busy = (state==GRANT).

IDLE behaviour:
- If any req_valid is high, scan from rr_ptr upward, modulo N_REQ.
- The first set index becomes owner; beat_cnt <= 0; next state is GRANT.
- Otherwise stay in IDLE.

GRANT behaviour, evaluated per edge in this priority order:
1. If req_valid[owner] is low, release.
2. Otherwise, if winc is high: beat_cnt += 1 and xfer_count += 1. If beat_cnt+1 == MAX_BURST, release.
3. Otherwise (full is high), hold: no count change and no release.

Release means: state <= IDLE, rr_ptr <= (owner+1) mod N_REQ, beat_cnt <= 0.

Boundary conditions:
- **full stall:** the grant is held indefinitely. Stall cycles do not consume the burst budget.
- **Owner drops valid mid-burst:** release at that edge. Beats already accepted remain counted.
- **Only one requester active:** it is re-granted after each release, with one IDLE cycle between grants.
- **rr_ptr wrap:** owner N_REQ-1 releases to rr_ptr 0.
- **Non-owner valid changes during GRANT:** ignored until the next IDLE scan.
- **Reset mid-burst:** winc and req_ready are forced low in the reset cycle, so no beat is accepted or counted. At the edge all registers return to their reset values.

## Timing

Reset values (after a rst edge):
- state IDLE
- owner 0, grant_id 0
- rr_ptr 0
- beat_cnt 0
- xfer_count 0
- busy 0, winc 0, req_ready 0

Latency and throughput:
- Arbitration latency: valid seen in IDLE at edge k gives GRANT from k+1, so the first winc is possible in cycle k+1 and the first accept happens at edge k+2.
- Within a grant, throughput is one beat per cycle while valid is high and full is low.
- Between owners there is exactly one IDLE cycle: a release at edge k is followed by the next grant visible after edge k+1.
- winc, req_ready and wdata are combinational from registered state plus req_valid/full/rst. There is no registered-output delay.
- The FIFO write side must see winc in the same cycle it evaluates its own full.

## Test plan

1. **Reset then single requester, burst limit.** Hold rst one cycle; then req_valid=0001 continuously with full=0 and MAX_BURST=4.
   - Expect 4 winc beats, then 1 busy=0 cycle, then 4 more, repeating.
   - Expect grant_id=0 throughout and xfer_count=8 after two bursts.
2. **Round-robin fairness.** req_valid=1111 held, data of requester i = 0xi0+beat.
   - Expect grant order 0,1,2,3,0, each for 4 beats.
   - Expect wdata to match the owner slice on every winc.
3. **full backpressure.** Requester 2 granted; assert full for 5 cycles after beat 1.
   - Expect winc=0 and req_ready=0 during the stall, with busy=1 and grant held.
   - Expect the remaining 3 beats after full drops; total 4 beats for the grant.
4. **Early valid drop.** Requester 1 deasserts valid after 2 beats while requester 3 is valid.
   - Expect release at that edge, one IDLE cycle, then grant_id=3.
   - Expect xfer_count to increase by 2 for requester 1.
5. **Reset mid-burst.** Assert rst during beat 3 of a grant.
   - Expect winc=0 in that cycle and no beat counted.
   - After the edge expect busy=0, xfer_count=0 and rr_ptr=0; with req_valid=1010 the next grant goes to requester 1.
6. **Wrap.** Owner 3 releases with req_valid=1001.
   - Expect the next grant_id=0, then 3 again after the following release.
